rx_deframer: RTL and testbench

//  Downstream of the boundary detector: consumes its BD_flag/BD_sgn and the raw BPSK symbol stream.

---
 rtl/rx_deframer_pkg.sv | 22 ++
 rtl/rx_deframer_crc8.sv | 24 ++
 rtl/rx_deframer.sv | 178 +++++++++++++++++
 tb/tb_rx_deframer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_deframer_pkg.sv
// Shared definitions for the rx_deframer slice: FSM state encoding and CRC-8 constants.
package rx_deframer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SKIP = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CRC  = 3'd4,
    ST_DONE = 3'd5,
    ST_CLR  = 3'd6
  } rx_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One serial CRC-8 step, data bit taken MSB-first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    return {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/rx_deframer_crc8.sv
// Serial bit-in CRC-8 (poly 0x07, init 0x00) with synchronous clear and enable.
module rx_deframer_crc8
  import rx_deframer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  // CRC register: cleared between packets, advanced one bit per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC8_INIT;
    end else if (clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= crc8_step(crc, din);
    end
  end

endmodule

// File: rtl/rx_deframer.sv
// rx_deframer: sign-corrects the BPSK stream after a boundary, parses a length header
// and emits payload bytes with start/end/error strobes, then re-arms the detector.
// Optional build macro RX_CRC_EN appends an 8-bit CRC field checked after the payload.
//
// state | meaning
// IDLE  | waiting for a BD_flag rising edge
// SKIP  | discarding RX_HDR_SKIP training-tail symbols
// HDR   | shifting in the length header, MSB first
// PAY   | shifting in payload bytes
// CRC   | shifting in the received CRC byte (RX_CRC_EN only)
// DONE  | packet complete, disassert_BD follows
// CLR   | waiting for the stale BD_flag to drop
module rx_deframer
  import rx_deframer_pkg::*;
#(
  parameter int MAX_WINDOW_WIDTH = 8,
  parameter int LEN_WIDTH        = 8,
  parameter int MAX_LEN_BYTES    = 200
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [MAX_WINDOW_WIDTH-1:0] RX_HDR_SKIP,
  input  logic                        BPSK,
  input  logic                        PD_flag,
  input  logic                        BD_flag,
  input  logic                        BD_sgn,
  output logic [7:0]                  byte_data,
  output logic                        byte_vld,
  output logic                        pkt_start,
  output logic                        pkt_end,
  output logic [LEN_WIDTH-1:0]        pkt_len,
  output logic                        pkt_err,
  output logic                        crc_ok,
  output logic                        disassert_BD
);

  localparam int                   HCW      = $clog2(LEN_WIDTH + 1);
  localparam logic [HCW-1:0]       HDR_BITS = HCW'(LEN_WIDTH);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(MAX_LEN_BYTES);

  rx_state_t                   state, state_nxt;
  logic                        bd_d, sgn_q, bit_c, bd_rise, abort;
  logic [MAX_WINDOW_WIDTH-1:0] skip_cnt;
  logic [HCW-1:0]              hdr_cnt;
  logic [2:0]                  bit_cnt;
  logic [LEN_WIDTH-1:0]        byte_rem, len_now;
  logic [LEN_WIDTH-2:0]        hdr_sh;
  logic [6:0]                  pay_sh;
  logic                        hdr_last, byte_last, pay_last, crc_last;
  logic                        vld_nxt, start_nxt, end_nxt, err_nxt, dis_nxt;

  assign bit_c     = BPSK ^ ~sgn_q;
  assign bd_rise   = BD_flag & ~bd_d;
  assign len_now   = {hdr_sh, bit_c};
  assign hdr_last  = (state == ST_HDR) && (hdr_cnt == HCW'(1));
  assign byte_last = (state == ST_PAY) && (bit_cnt == 3'd7);
  assign pay_last  = byte_last && (byte_rem == LEN_WIDTH'(1));
  assign crc_last  = (state == ST_CRC) && (bit_cnt == 3'd7);
  // IDLE and CLR are already quiescent, so PD loss only matters elsewhere.
  assign abort     = ~PD_flag && (state inside {ST_SKIP, ST_HDR, ST_PAY, ST_CRC, ST_DONE});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; PD loss overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bd_rise) state_nxt = (RX_HDR_SKIP == '0) ? ST_HDR : ST_SKIP;
      ST_SKIP: if (skip_cnt == MAX_WINDOW_WIDTH'(1)) state_nxt = ST_HDR;
      ST_HDR:  if (hdr_last) state_nxt = ((len_now == '0) || (len_now > MAX_LEN)) ? ST_DONE : ST_PAY;
`ifdef RX_CRC_EN
      ST_PAY:  if (pay_last) state_nxt = ST_CRC;
`else
      ST_PAY:  if (pay_last) state_nxt = ST_DONE;
`endif
      ST_CRC:  if (crc_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_CLR;
      ST_CLR:  if (!BD_flag) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // Output strobe decode; a byte completing on the abort cycle is still emitted.
  always_comb begin
    vld_nxt   = byte_last;
    start_nxt = byte_last && (byte_rem == pkt_len);
    end_nxt   = PD_flag && hdr_last && (len_now == '0);
`ifdef RX_CRC_EN
    end_nxt   = end_nxt || (PD_flag && crc_last);
`else
    end_nxt   = end_nxt || (PD_flag && pay_last);
`endif
    err_nxt   = (abort && (state inside {ST_HDR, ST_PAY, ST_CRC})) ||
                (PD_flag && hdr_last && (len_now > MAX_LEN));
    dis_nxt   = (state == ST_DONE) && PD_flag;
  end

  // Counters, shift registers and the latched boundary polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bd_d     <= 1'b0;
      sgn_q    <= 1'b0;
      skip_cnt <= '0;
      hdr_cnt  <= '0;
      bit_cnt  <= '0;
      byte_rem <= '0;
      hdr_sh   <= '0;
      pay_sh   <= '0;
    end else begin
      bd_d <= BD_flag;
      if ((state == ST_IDLE) && bd_rise) sgn_q <= BD_sgn;
      if (state == ST_IDLE)      skip_cnt <= RX_HDR_SKIP;
      else if (state == ST_SKIP) skip_cnt <= skip_cnt - MAX_WINDOW_WIDTH'(1);
      if (state == ST_HDR) begin
        hdr_cnt <= hdr_cnt - HCW'(1);
        hdr_sh  <= len_now[LEN_WIDTH-2:0];
      end else begin
        hdr_cnt <= HDR_BITS;
      end
      if (state inside {ST_PAY, ST_CRC}) begin
        bit_cnt <= bit_cnt + 3'd1;
        pay_sh  <= {pay_sh[5:0], bit_c};
      end else begin
        bit_cnt <= '0;
      end
      if (hdr_last)       byte_rem <= len_now;
      else if (byte_last) byte_rem <= byte_rem - LEN_WIDTH'(1);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_data    <= '0;
      byte_vld     <= 1'b0;
      pkt_start    <= 1'b0;
      pkt_end      <= 1'b0;
      pkt_len      <= '0;
      pkt_err      <= 1'b0;
      disassert_BD <= 1'b0;
    end else begin
      byte_vld     <= vld_nxt;
      pkt_start    <= start_nxt;
      pkt_end      <= end_nxt;
      pkt_err      <= err_nxt;
      disassert_BD <= dis_nxt;
      if (byte_last)            byte_data <= {pay_sh, bit_c};
      if (hdr_last && PD_flag)  pkt_len   <= len_now;
    end
  end

`ifdef RX_CRC_EN
  logic [7:0] crc_calc;

  rx_deframer_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .en    (state == ST_PAY),
    .din   (bit_c),
    .crc   (crc_calc)
  );

  // CRC verdict, updated with each pkt_end; an empty payload has nothing to check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       crc_ok <= 1'b1;
    else if (end_nxt) crc_ok <= crc_last ? ({pay_sh, bit_c} == crc_calc) : 1'b1;
  end
`else
  assign crc_ok = 1'b1;
`endif

endmodule

// File: tb/tb_rx_deframer.sv
// Self-checking bench for rx_deframer: randomized packets against a timing/byte model.
module tb_rx_deframer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] RX_HDR_SKIP;
  logic       BPSK, PD_flag, BD_flag, BD_sgn;
  logic [7:0] byte_data;
  logic       byte_vld, pkt_start, pkt_end, pkt_err, crc_ok, disassert_BD;
  logic [7:0] pkt_len;

  rx_deframer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RX_HDR_SKIP  (RX_HDR_SKIP),
    .BPSK         (BPSK),
    .PD_flag      (PD_flag),
    .BD_flag      (BD_flag),
    .BD_sgn       (BD_sgn),
    .byte_data    (byte_data),
    .byte_vld     (byte_vld),
    .pkt_start    (pkt_start),
    .pkt_end      (pkt_end),
    .pkt_len      (pkt_len),
    .pkt_err      (pkt_err),
    .crc_ok       (crc_ok),
    .disassert_BD (disassert_BD)
  );

  always #5 clk = ~clk;

`ifdef RX_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  // fl = {byte_vld, pkt_start, pkt_end, pkt_err, disassert_BD, crc_ok-at-pkt_end}
  typedef struct packed {
    int         rel;
    logic [7:0] data;
    logic [5:0] fl;
  } ev_t;

  int         cyc = 0;
  int         t0 = 0;
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         failures = 0;
  ev_t        mon_q[$];
  ev_t        exp_q[$];
  logic [7:0] pay_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe cycle, timestamped relative to the BD_flag rise.
  always @(negedge clk) begin
    if (mon_en && rst_n && (byte_vld || pkt_start || pkt_end || pkt_err || disassert_BD)) begin
      ev_t e;
      e.rel  = cyc - t0;
      e.data = byte_vld ? byte_data : 8'h00;
      e.fl   = {byte_vld, pkt_start, pkt_end, pkt_err, disassert_BD, (pkt_end ? crc_ok : 1'b1)};
      mon_q.push_back(e);
    end
  end

  function automatic ev_t mk(input int rel, input logic [7:0] d, input logic [5:0] fl);
    ev_t e;
    e.rel  = rel;
    e.data = d;
    e.fl   = fl;
    return e;
  endfunction

  function automatic logic [7:0] crc8_model();
    logic [7:0] c;
    c = 8'h00;
    foreach (pay_q[i]) begin
      c = c ^ pay_q[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Drives one packet (payload taken from pay_q) and builds the expected strobe list.
  // abort_byte >= 0 drops PD_flag on the last bit of that payload byte.
  // crc_byte < 0 sends the correct CRC (only when the CRC field exists).
  task automatic run_pkt(input int s, input bit sgn, input int hdr, input int abort_byte,
                         input int crc_byte);
    bit         bits[$];
    int         len, base, n, abort_rel;
    logic [7:0] crc_tx, crc_ref, hv;
    bit         ok;
    len     = (hdr >= 1 && hdr <= 200) ? hdr : 0;
    crc_ref = crc8_model();
    crc_tx  = (crc_byte < 0) ? crc_ref : 8'(crc_byte);
    ok      = (crc_tx == crc_ref);
    hv      = 8'(hdr);
    for (int i = 0; i < s; i++) bits.push_back(1'($urandom));
    for (int i = 7; i >= 0; i--) bits.push_back(hv[i]);
    for (int j = 0; j < len; j++) begin
      hv = pay_q[j];
      for (int i = 7; i >= 0; i--) bits.push_back(hv[i]);
    end
    if (CRC_EN && len > 0)
      for (int i = 7; i >= 0; i--) bits.push_back(crc_tx[i]);
    for (int i = 0; i < 6; i++) bits.push_back(1'($urandom));

    exp_q.delete();
    base      = s + 8;
    abort_rel = s + 16 + 8 * abort_byte;
    if (hdr == 0) begin
      exp_q.push_back(mk(base, 8'h00, 6'b001001));
      exp_q.push_back(mk(base + 1, 8'h00, 6'b000011));
    end else if (hdr > 200) begin
      exp_q.push_back(mk(base, 8'h00, 6'b000101));
      exp_q.push_back(mk(base + 1, 8'h00, 6'b000011));
    end else begin
      n = (abort_byte >= 0) ? abort_byte + 1 : len;
      for (int j = 0; j < n; j++)
        exp_q.push_back(mk(base + 8 * (j + 1), pay_q[j],
                           {1'b1, (j == 0), (!CRC_EN && abort_byte < 0 && j == len - 1),
                            (j == abort_byte), 1'b0, 1'b1}));
      if (abort_byte < 0 && CRC_EN) begin
        exp_q.push_back(mk(base + 8 * len + 8, 8'h00, {5'b00100, ok}));
        exp_q.push_back(mk(base + 8 * len + 9, 8'h00, 6'b000011));
      end else if (abort_byte < 0) begin
        exp_q.push_back(mk(base + 8 * len + 1, 8'h00, 6'b000011));
      end
    end

    mon_q.delete();
    RX_HDR_SKIP = 8'(s);
    @(negedge clk);
    t0      = cyc + 1;
    BD_flag = 1'b1;
    BD_sgn  = sgn;
    PD_flag = 1'b1;
    mon_en  = 1'b1;
    foreach (bits[i]) begin
      @(negedge clk);
      BD_sgn = ~sgn;
      BPSK   = bits[i] ^ ~sgn;
      if (abort_byte >= 0 && i + 1 == abort_rel) PD_flag = 1'b0;
    end
    @(negedge clk);
    BD_flag = 1'b0;
    BD_sgn  = 1'b0;
    repeat (4) @(negedge clk);
    PD_flag = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_data, byte_vld, pkt_start, pkt_end, pkt_len, pkt_err, crc_ok, disassert_BD}
        !== {8'h00, 3'b000, 8'h00, 3'b010}) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h",
               {byte_data, byte_vld, pkt_start, pkt_end, pkt_len, pkt_err, crc_ok, disassert_BD},
               {8'h00, 3'b000, 8'h00, 3'b010});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({byte_vld, pkt_start, pkt_end, pkt_err, crc_ok, disassert_BD} !== 6'b000010) begin
      failures++;
      $display("FAIL reset_idle got=%b want=000010",
               {byte_vld, pkt_start, pkt_end, pkt_err, crc_ok, disassert_BD});
    end
  endtask

  // Same A5 3C FF packet with both boundary polarities.
  task automatic test_basic();
    for (int r = 0; r < 2; r++) begin
      pay_q = '{8'hA5, 8'h3C, 8'hFF};
      run_pkt(2, (r == 0), 3, -1, -1);
      checks++;
      if (mon_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL basic_nev run=%0d got=%0d want=%0d", r, mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
        checks++;
        if (mon_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL basic_ev%0d run=%0d got rel=%0d data=%h fl=%b want rel=%0d data=%h fl=%b",
                   i, r, mon_q[i].rel, mon_q[i].data, mon_q[i].fl,
                   exp_q[i].rel, exp_q[i].data, exp_q[i].fl);
        end
      end
      checks++;
      if (pkt_len !== 8'd3) begin
        failures++;
        $display("FAIL basic_len run=%0d got=%0d want=3", r, pkt_len);
      end
    end
  endtask

  // Zero-length header, then a fresh packet proves the FSM got back to IDLE.
  task automatic test_zero_len();
    int hdr;
    for (int r = 0; r < 2; r++) begin
      hdr = (r == 0) ? 0 : 2;
      pay_q.delete();
      if (r == 1) pay_q = '{8'h5A, 8'hC3};
      run_pkt((r == 0) ? 1 : 0, 1'b1, hdr, -1, -1);
      checks++;
      if (mon_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL zero_nev run=%0d got=%0d want=%0d", r, mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
        checks++;
        if (mon_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL zero_ev%0d run=%0d got rel=%0d data=%h fl=%b want rel=%0d data=%h fl=%b",
                   i, r, mon_q[i].rel, mon_q[i].data, mon_q[i].fl,
                   exp_q[i].rel, exp_q[i].data, exp_q[i].fl);
        end
      end
      checks++;
      if (pkt_len !== 8'(hdr)) begin
        failures++;
        $display("FAIL zero_len run=%0d got=%0d want=%0d", r, pkt_len, hdr);
      end
    end
  endtask

  // Oversized headers and the largest legal length.
  task automatic test_len_limit();
    int hdrs[3] = '{250, 201, 200};
    for (int r = 0; r < 3; r++) begin
      pay_q.delete();
      for (int j = 0; j < 200; j++) pay_q.push_back(8'($urandom));
      if (hdrs[r] > 200) pay_q.delete();
      run_pkt(3, 1'($urandom), hdrs[r], -1, -1);
      checks++;
      if (mon_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL limit_nev hdr=%0d got=%0d want=%0d", hdrs[r], mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
        checks++;
        if (mon_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL limit_ev%0d hdr=%0d got rel=%0d data=%h fl=%b want rel=%0d data=%h fl=%b",
                   i, hdrs[r], mon_q[i].rel, mon_q[i].data, mon_q[i].fl,
                   exp_q[i].rel, exp_q[i].data, exp_q[i].fl);
        end
      end
      checks++;
      if (pkt_len !== 8'(hdrs[r])) begin
        failures++;
        $display("FAIL limit_len got=%0d want=%0d", pkt_len, hdrs[r]);
      end
    end
  endtask

  // PD loss on the cycle the first of three bytes completes, then a clean packet.
  task automatic test_abort();
    for (int r = 0; r < 2; r++) begin
      pay_q = '{8'h81, 8'h7E, 8'h42};
      run_pkt(2, 1'b0, 3, (r == 0) ? 0 : -1, -1);
      checks++;
      if (mon_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL abort_nev run=%0d got=%0d want=%0d", r, mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
        checks++;
        if (mon_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL abort_ev%0d run=%0d got rel=%0d data=%h fl=%b want rel=%0d data=%h fl=%b",
                   i, r, mon_q[i].rel, mon_q[i].data, mon_q[i].fl,
                   exp_q[i].rel, exp_q[i].data, exp_q[i].fl);
        end
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 20; r++) begin
      len = int'($urandom_range(1, 8));
      pay_q.delete();
      for (int j = 0; j < len; j++) pay_q.push_back(8'($urandom));
      run_pkt(int'($urandom_range(0, 5)), 1'($urandom), len, -1, -1);
      checks++;
      if (mon_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rand_nev run=%0d got=%0d want=%0d", r, mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
        checks++;
        if (mon_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand_ev%0d run=%0d got rel=%0d data=%h fl=%b want rel=%0d data=%h fl=%b",
                   i, r, mon_q[i].rel, mon_q[i].data, mon_q[i].fl,
                   exp_q[i].rel, exp_q[i].data, exp_q[i].fl);
        end
      end
    end
  endtask

`ifdef RX_CRC_EN
  // Payload 01 02: CRC-8 is 0x1B; 0x1C must be flagged bad.
  task automatic test_crc();
    int crcs[2] = '{8'h1B, 8'h1C};
    for (int r = 0; r < 2; r++) begin
      pay_q = '{8'h01, 8'h02};
      run_pkt(1, 1'b1, 2, -1, crcs[r]);
      checks++;
      if (mon_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL crc_nev run=%0d got=%0d want=%0d", r, mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
        checks++;
        if (mon_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL crc_ev%0d run=%0d got rel=%0d data=%h fl=%b want rel=%0d data=%h fl=%b",
                   i, r, mon_q[i].rel, mon_q[i].data, mon_q[i].fl,
                   exp_q[i].rel, exp_q[i].data, exp_q[i].fl);
        end
      end
    end
  endtask
`endif

  initial begin
    RX_HDR_SKIP = 8'd0;
    BPSK        = 1'b0;
    PD_flag     = 1'b1;
    BD_flag     = 1'b0;
    BD_sgn      = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_len_limit();
    test_abort();
    test_random();
`ifdef RX_CRC_EN
    test_crc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
